// File: rtl/dac_sched_pkg.sv
// Shared types and helpers for the multi-channel DAC frame scheduler.
package dac_sched_pkg;

  localparam int DAC_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } schedState_t;

  // Width of an index able to address n items; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping at N_CH.
module dac_rr_arbiter
  import dac_sched_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int IW = idxWidth(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [N_CH-1:0] o_grant,
  output logic [IW-1:0]   o_grantIdx,
  output logic            o_valid
);

  logic [IW:0] w_cand;

  // One extra bit keeps ptr+i from overflowing before the modulo wrap.
  always_comb begin
    o_grant    = '0;
    o_grantIdx = '0;
    o_valid    = 1'b0;
    w_cand     = '0;
    for (int i = 1; i <= N_CH; i++) begin
      w_cand = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_cand >= (IW+1)'(N_CH)) begin
        w_cand = w_cand - (IW+1)'(N_CH);
      end
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid                     = 1'b1;
        o_grantIdx                  = w_cand[IW-1:0];
        o_grant[w_cand[IW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler sharing one serial DAC bus between N_CH requesters (16-bit MSB-first frames).
// Optional idle refresh of held channel values is enabled by defining DAC_SCHED_REFRESH_EN.
module dac_frame_scheduler
  import dac_sched_pkg::*;
#(
  parameter int                    N_CH       = 4,
  parameter int                    GAP_CYCLES = 1,
  parameter logic [DAC_WORD_W-1:0] RESET_CODE = 16'h8000
) (
  input  logic                         DAC_clock,
  input  logic                         reset,
  input  logic [N_CH-1:0]              req,
  input  logic [DAC_WORD_W*N_CH-1:0]   req_data,
  output logic [N_CH-1:0]              ack,
  output logic                         DAC_serial_data,
  output logic [N_CH-1:0]              DAC_word_sync,
  output logic                         DAC_reset,
  output logic                         busy,
  output logic [idxWidth(N_CH)-1:0]    active_ch
);

  localparam int IW = idxWidth(N_CH);
  localparam int BW = idxWidth(DAC_WORD_W);
  localparam int GW = idxWidth(GAP_CYCLES);

  schedState_t                      r_state, w_stateNext;
  logic [N_CH-1:0]                  r_sync, w_syncNext;
  logic                             r_data, w_dataNext;
  logic [DAC_WORD_W-1:0]            r_shift, w_shiftNext;
  logic [BW-1:0]                    r_bitIdx, w_bitIdxNext;
  logic [GW-1:0]                    r_gapCnt, w_gapCntNext;
  logic [N_CH-1:0]                  r_ack, w_ackNext;
  logic                             r_busy, w_busyNext;
  logic [IW-1:0]                    r_activeCh, w_activeNext;
  logic [IW-1:0]                    r_rrPtr, w_rrPtrNext;
  logic [N_CH-1:0][DAC_WORD_W-1:0]  r_held;
  logic                             w_capture;

  logic [N_CH-1:0]                  w_reqGrant;
  logic [IW-1:0]                    w_reqIdx;
  logic                             w_reqValid;
  logic [DAC_WORD_W-1:0]            w_reqWord;

  logic                             w_startValid;
  logic [N_CH-1:0]                  w_startGrant;
  logic [IW-1:0]                    w_startIdx;
  logic [DAC_WORD_W-1:0]            w_startWord;

  dac_rr_arbiter #(.N_CH(N_CH)) u_reqArb (
    .i_req      (req),
    .i_ptr      (r_rrPtr),
    .o_grant    (w_reqGrant),
    .o_grantIdx (w_reqIdx),
    .o_valid    (w_reqValid)
  );

  assign w_reqWord = req_data[int'(w_reqIdx)*DAC_WORD_W +: DAC_WORD_W];

`ifdef DAC_SCHED_REFRESH_EN
  logic [IW-1:0]   r_refPtr, w_refPtrNext;
  logic [N_CH-1:0] w_refGrant;
  logic [IW-1:0]   w_refIdx;
  logic            w_refValid;

  // The same rotation logic with every input set simply steps the refresh pointer by one.
  dac_rr_arbiter #(.N_CH(N_CH)) u_refArb (
    .i_req      ({N_CH{1'b1}}),
    .i_ptr      (r_refPtr),
    .o_grant    (w_refGrant),
    .o_grantIdx (w_refIdx),
    .o_valid    (w_refValid)
  );

  assign w_startValid = w_reqValid | w_refValid;
  assign w_startGrant = w_reqValid ? w_reqGrant : w_refGrant;
  assign w_startIdx   = w_reqValid ? w_reqIdx   : w_refIdx;
  assign w_startWord  = w_reqValid ? w_reqWord  : r_held[w_refIdx];

  always_ff @(posedge DAC_clock) begin
    if (reset) begin
      r_refPtr <= IW'(N_CH-1);
    end else begin
      r_refPtr <= w_refPtrNext;
    end
  end
`else
  logic w_unusedHeld;

  assign w_startValid = w_reqValid;
  assign w_startGrant = w_reqGrant;
  assign w_startIdx   = w_reqIdx;
  assign w_startWord  = w_reqWord;
  assign w_unusedHeld = ^r_held;
`endif

  always_comb begin
    w_stateNext  = r_state;
    w_syncNext   = r_sync;
    w_dataNext   = r_data;
    w_shiftNext  = r_shift;
    w_bitIdxNext = r_bitIdx;
    w_gapCntNext = r_gapCnt;
    w_ackNext    = '0;
    w_busyNext   = r_busy;
    w_activeNext = r_activeCh;
    w_rrPtrNext  = r_rrPtr;
    w_capture    = 1'b0;
`ifdef DAC_SCHED_REFRESH_EN
    w_refPtrNext = r_refPtr;
`endif
    case (r_state)
      IDLE: begin
        w_syncNext = '1;
        w_dataNext = 1'b0;
        w_busyNext = 1'b0;
        if (w_startValid) begin
          w_syncNext   = ~w_startGrant;
          w_dataNext   = w_startWord[DAC_WORD_W-1];
          w_shiftNext  = {w_startWord[DAC_WORD_W-2:0], 1'b0};
          w_bitIdxNext = BW'(DAC_WORD_W-1);
          w_activeNext = w_startIdx;
          w_busyNext   = 1'b1;
          w_stateNext  = SHIFT;
          // Only real requests are acked and advance fairness; refresh frames leave both untouched.
          if (w_reqValid) begin
            w_capture   = 1'b1;
            w_ackNext   = w_reqGrant;
            w_rrPtrNext = w_reqIdx;
          end
`ifdef DAC_SCHED_REFRESH_EN
          else begin
            w_refPtrNext = w_refIdx;
          end
`endif
        end
      end
      SHIFT: begin
        // r_bitIdx names the bit currently on the line; the frame ends once bit 0 has had its cycle.
        if (r_bitIdx == '0) begin
          w_syncNext   = '1;
          w_dataNext   = 1'b0;
          w_gapCntNext = GW'(GAP_CYCLES-1);
          w_stateNext  = GAP;
        end else begin
          w_dataNext   = r_shift[DAC_WORD_W-1];
          w_shiftNext  = {r_shift[DAC_WORD_W-2:0], 1'b0};
          w_bitIdxNext = r_bitIdx - BW'(1);
        end
      end
      GAP: begin
        if (r_gapCnt == '0) begin
          w_busyNext  = 1'b0;
          w_stateNext = IDLE;
        end else begin
          w_gapCntNext = r_gapCnt - GW'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge DAC_clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sync     <= '1;
      r_data     <= 1'b0;
      r_shift    <= '0;
      r_bitIdx   <= '0;
      r_gapCnt   <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_activeCh <= '0;
      r_rrPtr    <= IW'(N_CH-1);
    end else begin
      r_state    <= w_stateNext;
      r_sync     <= w_syncNext;
      r_data     <= w_dataNext;
      r_shift    <= w_shiftNext;
      r_bitIdx   <= w_bitIdxNext;
      r_gapCnt   <= w_gapCntNext;
      r_ack      <= w_ackNext;
      r_busy     <= w_busyNext;
      r_activeCh <= w_activeNext;
      r_rrPtr    <= w_rrPtrNext;
    end
  end

  always_ff @(posedge DAC_clock) begin
    if (reset) begin
      r_held <= {N_CH{RESET_CODE}};
    end else if (w_capture) begin
      r_held[w_reqIdx] <= w_reqWord;
    end
  end

  assign ack             = r_ack;
  assign DAC_serial_data = r_data;
  assign DAC_word_sync   = r_sync;
  assign DAC_reset       = reset;
  assign busy            = r_busy;
  assign active_ch       = r_activeCh;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler; the refresh scenario runs when DAC_SCHED_REFRESH_EN is defined.
module tb_dac_frame_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, ack, sync;
  logic [16*N-1:0] reqData;
  logic           serData, dacReset, busy;
  logic [1:0]     activeCh;

  logic [N-1:0]   req3, ack3, sync3;
  logic [16*N-1:0] reqData3;
  logic           serData3, dacReset3, busy3;
  logic [1:0]     activeCh3;

  always #5 clk = ~clk;

  dac_frame_scheduler #(.N_CH(N), .GAP_CYCLES(1), .RESET_CODE(16'h8000)) u_dut (
    .DAC_clock(clk), .reset(reset), .req(req), .req_data(reqData), .ack(ack),
    .DAC_serial_data(serData), .DAC_word_sync(sync), .DAC_reset(dacReset),
    .busy(busy), .active_ch(activeCh)
  );

  dac_frame_scheduler #(.N_CH(N), .GAP_CYCLES(3), .RESET_CODE(16'h8000)) u_dut3 (
    .DAC_clock(clk), .reset(reset), .req(req3), .req_data(reqData3), .ack(ack3),
    .DAC_serial_data(serData3), .DAC_word_sync(sync3), .DAC_reset(dacReset3),
    .busy(busy3), .active_ch(activeCh3)
  );

  typedef struct {
    int          ch;
    logic [15:0] word;
    int          len;
    bit          acked;
    int          period;
  } frame_t;

  frame_t expQ[$];
  int     nChecks = 0, nPass = 0;
  int     expAcks = 0, totalAcks = 0;
  int     busyCnt = 0, lastBusyRun = 0;
  int     cyc = 0, lastStart = 0, curPeriod = 0;
  int     fCh = 0, fLen = 0, fActive = 0;
  logic [15:0] fBits;
  bit     fAck, fBad, inFrame = 1'b0, monitorEn = 1'b1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic pushFrame(input int ch, input logic [15:0] word, input int len, input bit acked, input int period);
    frame_t f;
    f.ch = ch; f.word = word; f.len = len; f.acked = acked; f.period = period;
    expQ.push_back(f);
    if (acked) expAcks++;
  endtask

  task automatic applyStimulus(input int ch, input logic [15:0] word);
    reqData[16*ch +: 16] = word;
    req[ch] = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitAck(input int ch, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[ch] && n < budget);
    checkOutput($sformatf("ackWait%0d", ch), 32'(ack[ch]), 1);
  endtask

  task automatic serveReqs(input int budget);
    int n = 0;
    while (req != '0 && n < budget) begin
      @(negedge clk);
      n++;
      for (int c = 0; c < N; c++) if (ack[c]) req[c] = 1'b0;
    end
    checkOutput("serveDone", 32'(req), 0);
  endtask

  task automatic drainSb(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sbDrained", expQ.size(), 0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    waitCycles(2);
    checkOutput("rstSync", 32'(sync), 32'hF);
    checkOutput("rstData", 32'(serData), 0);
    checkOutput("rstAck", 32'(ack), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstActive", 32'(activeCh), 0);
    checkOutput("rstPass", 32'(dacReset), 1);
    reset = 1'b0;
  endtask

  task automatic checkFrame();
    frame_t f;
    checkOutput("sbHasFrame", 32'(expQ.size() != 0), 1);
    if (expQ.size() != 0) begin
      f = expQ.pop_front();
      checkOutput("frameCh", fCh, f.ch);
      checkOutput("frameActive", fActive, f.ch);
      checkOutput("frameWord", 32'(fBits), 32'(f.word));
      checkOutput("frameLen", fLen, f.len);
      checkOutput("frameAck", 32'(fAck), 32'(f.acked));
      checkOutput("singleSync", 32'(fBad), 0);
      if (f.period != 0) checkOutput("framePeriod", curPeriod, f.period);
    end
  endtask

  // Monitor: rebuild frames from the bus and hand each finished one to the scoreboard.
  always @(negedge clk) begin
    cyc++;
    totalAcks += $countones(ack);
    if (busy) busyCnt++;
    else if (busyCnt != 0) begin
      lastBusyRun = busyCnt;
      busyCnt = 0;
    end
    if (!monitorEn) inFrame = 1'b0;
    else if (sync != 4'hF) begin
      if (!inFrame) begin
        inFrame = 1'b1;
        for (int c = N-1; c >= 0; c--) if (!sync[c]) fCh = c;
        fActive = int'(activeCh);
        fLen = 0; fBits = '0; fAck = 1'b0; fBad = 1'b0;
        curPeriod = cyc - lastStart;
        lastStart = cyc;
      end
      if (~sync != (4'b1 << fCh)) fBad = 1'b1;
      fBits = {fBits[14:0], serData};
      fLen++;
      if (fLen == 1 && ack == (4'b1 << fCh)) fAck = 1'b1;
    end else if (inFrame) begin
      inFrame = 1'b0;
      checkFrame();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, stopping");
    $fatal(1);
  end

  initial begin
    int nAcks, n, lo, hi;
    reset = 1'b1; req = '0; reqData = '0; req3 = '0; reqData3 = '0;
    resetDut();
`ifndef DAC_SCHED_REFRESH_EN
    // Single request on channel 2.
    applyStimulus(2, 16'hA5C3);
    pushFrame(2, 16'hA5C3, 16, 1, 0);
    serveReqs(60);
    waitCycles(25);
    checkOutput("busyLen", lastBusyRun, 17);

    // Channel 1 requests during channel 3's frame and withdraws before it ends.
    applyStimulus(3, 16'h0FF0);
    pushFrame(3, 16'h0FF0, 16, 1, 0);
    waitAck(3, 60);
    req[3] = 1'b0;
    waitCycles(4);
    applyStimulus(1, 16'h5555);
    waitCycles(5);
    req[1] = 1'b0;
    waitCycles(40);
    checkOutput("idleSync", 32'(sync), 32'hF);
    checkOutput("idleBusy", 32'(busy), 0);

    // Reset while channel 0 is driving bit 7; pointer restart gives channel 0 priority over 1.
    applyStimulus(0, 16'h3C5A);
    pushFrame(0, 16'h003C, 8, 1, 0);
    waitAck(0, 60);
    req[0] = 1'b0;
    applyStimulus(1, 16'h7E81);
    waitCycles(7);
    reset = 1'b1;
    applyStimulus(0, 16'hC3A5);
    @(negedge clk);
    checkOutput("midRstSync", 32'(sync), 32'hF);
    checkOutput("midRstData", 32'(serData), 0);
    checkOutput("midRstAck", 32'(ack), 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    reset = 1'b0;
    pushFrame(0, 16'hC3A5, 16, 1, 9);
    pushFrame(1, 16'h7E81, 16, 1, 18);
    serveReqs(80);
    drainSb(40);

    // All channels request continuously.
    resetDut();
    applyStimulus(0, 16'h1111);
    applyStimulus(1, 16'h2222);
    applyStimulus(2, 16'h3333);
    applyStimulus(3, 16'h4444);
    pushFrame(0, 16'h1111, 16, 1, 0);
    pushFrame(1, 16'h2222, 16, 1, 18);
    pushFrame(2, 16'h3333, 16, 1, 18);
    pushFrame(3, 16'h4444, 16, 1, 18);
    pushFrame(0, 16'h1111, 16, 1, 18);
    nAcks = 0; n = 0;
    while (nAcks < 5 && n < 150) begin
      @(negedge clk);
      n++;
      if (ack != '0) nAcks++;
    end
    req = '0;
    checkOutput("contAcks", nAcks, 5);
    drainSb(60);
    waitCycles(30);
`else
    // Refresh frames sweep all channels; a write to channel 1 slots in after the current frame.
    pushFrame(0, 16'h8000, 16, 0, 0);
    pushFrame(1, 16'h8000, 16, 0, 18);
    pushFrame(2, 16'h8000, 16, 0, 18);
    pushFrame(3, 16'h8000, 16, 0, 18);
    n = 0;
    while (sync[3] != 1'b0 && n < 120) begin
      @(negedge clk);
      n++;
    end
    checkOutput("refCh3Seen", 32'(sync[3]), 0);
    applyStimulus(1, 16'h1234);
    pushFrame(1, 16'h1234, 16, 1, 18);
    pushFrame(0, 16'h8000, 16, 0, 18);
    pushFrame(1, 16'h1234, 16, 0, 18);
    serveReqs(60);
    drainSb(120);
`endif
    checkOutput("sbEmpty", expQ.size(), 0);
    checkOutput("ackTotal", totalAcks, expAcks);
    monitorEn = 1'b0;

    // Three gap cycles: sync low 16 cycles, high 4, for a 20-cycle period.
    reqData3 = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    req3 = '1;
    n = 0;
    while (sync3 != 4'hF && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (sync3 == 4'hF && n < 120) begin
      @(negedge clk);
      n++;
    end
    for (int it = 0; it < 2; it++) begin
      lo = 0;
      while (sync3 != 4'hF && lo < 40) begin
        lo++;
        @(negedge clk);
      end
      checkOutput("gap3Low", lo, 16);
      hi = 0;
      while (sync3 == 4'hF && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      checkOutput("gap3High", hi, 4);
    end
    req3 = '0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
